// File: rtl/counter_btn_sequencer.sv
// counter_btn_sequencer
// Turns the four board push-buttons into single-cycle commands for an 8-bit
// up/down count register. Each button is synchronised and debounced. Presses
// that overlap are arbitrated R > L > U > D. Held up/down buttons auto-repeat.
//
// Ports:
//   clk       system clock (100 MHz)
//   rst       synchronous active-high reset
//   btnU      raw up button (async)         -> cmd_inc
//   btnL      raw load button (async)       -> cmd_load
//   btnR      raw clear button (async)      -> cmd_clr
//   btnD      raw down button (async)       -> cmd_dec
//   sw[7:0]   load value source, sampled on entry to FIRE
//   cmd_*     one-cycle, mutually exclusive command strobes
//   load_val  sw captured on the most recent FIRE entry
//   busy      high whenever the sequencer is not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no button accepted; waiting for any synchronised press
// DEBOUNCE | arbitrated code must stay equal to cap for DEB_CYCLES
// FIRE     | one cycle: strobe selected by cap is high
// HOLD     | up/down still held; waiting REPEAT_DELAY before auto-repeat
// REPEAT   | auto-repeating; waiting REPEAT_PERIOD between strobes
// RELEASE  | all buttons must stay low for DEB_CYCLES before IDLE

module counter_btn_sequencer #(
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic [7:0] sw,
  output logic       cmd_clr,
  output logic       cmd_load,
  output logic       cmd_inc,
  output logic       cmd_dec,
  output logic [7:0] load_val,
  output logic       busy
);

  localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 1);
  localparam logic [31:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_LAST  = 32'(REPEAT_PERIOD - 1);

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_R    = 3'd1;
  localparam logic [2:0] CODE_L    = 3'd2;
  localparam logic [2:0] CODE_U    = 3'd3;
  localparam logic [2:0] CODE_D    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_FIRE     = 3'd2,
    S_HOLD     = 3'd3,
    S_REPEAT   = 3'd4,
    S_RELEASE  = 3'd5
  } state_t;

  // bit order: {D, R, L, U}
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  state_t      r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_cap;
  logic        r_rep;
  logic [7:0]  r_load_val;

  state_t      w_state_next;
  logic [31:0] w_cnt_next;
  logic [2:0]  w_cap_next;
  logic        w_rep_next;
  logic [2:0]  w_code;
  logic        w_any;

  assign w_any = |r_sync2;

  // Fixed-priority arbitration of the synchronised buttons.
  always_comb begin
    w_code = CODE_NONE;
    if (r_sync2[2])      w_code = CODE_R;
    else if (r_sync2[1]) w_code = CODE_L;
    else if (r_sync2[0]) w_code = CODE_U;
    else if (r_sync2[3]) w_code = CODE_D;
  end

  // State register plus the small datapath that travels with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cap      <= CODE_NONE;
      r_rep      <= 1'b0;
      r_load_val <= '0;
    end else begin
      r_sync1 <= {btnD, btnR, btnL, btnU};
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cap   <= w_cap_next;
      r_rep   <= w_rep_next;
      // Every FIRE entry (first press or repeat) refreshes load_val.
      if (w_state_next == S_FIRE) r_load_val <= sw;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cap_next   = r_cap;
    w_rep_next   = r_rep;
    case (r_state)
      S_IDLE: begin
        if (w_code != CODE_NONE) begin
          w_cap_next   = w_code;
          w_cnt_next   = '0;
          w_rep_next   = 1'b0;
          w_state_next = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (w_code != r_cap) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = S_FIRE;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      S_FIRE: begin
        w_cnt_next = '0;
        if (r_cap == CODE_R || r_cap == CODE_L) w_state_next = S_RELEASE;
        else if (r_rep)                         w_state_next = S_REPEAT;
        else                                    w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_code != r_cap) begin
          w_cnt_next   = '0;
          w_state_next = S_RELEASE;
        end else if (r_cnt == RD_LAST) begin
          w_rep_next   = 1'b1;
          w_state_next = S_FIRE;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      S_REPEAT: begin
        if (w_code != r_cap) begin
          w_cnt_next   = '0;
          w_state_next = S_RELEASE;
        end else if (r_cnt == RP_LAST) begin
          w_state_next = S_FIRE;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      S_RELEASE: begin
        // Any button still high restarts the release qualification.
        if (w_any) begin
          w_cnt_next = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so they are glitch-free.
  always_comb begin
    cmd_clr  = 1'b0;
    cmd_load = 1'b0;
    cmd_inc  = 1'b0;
    cmd_dec  = 1'b0;
    if (r_state == S_FIRE) begin
      cmd_clr  = (r_cap == CODE_R);
      cmd_load = (r_cap == CODE_L);
      cmd_inc  = (r_cap == CODE_U);
      cmd_dec  = (r_cap == CODE_D);
    end
    busy     = (r_state != S_IDLE);
    load_val = r_load_val;
  end

endmodule
